dds_phase_sequencer: RTL
========================

# dds_phase_sequencer

Phase-accumulator controller for the DDS waveform path. It owns the frequency tuning word (FTW) and the waveform mode, and drives the Address_o/Mode_o pair consumed by the mode-dependent address filter. Configuration changes requested while running are held and committed only at a phase wrap, so output waveforms change mode and frequency glitch-free at a cycle boundary.

## Interface
- ACC_W, default 24: phase accumulator width in bits.
- ADDR_W, default 11: address width presented to the filter/ROM; must satisfy ADDR_W ≤ ACC_W.
- MODE_W, default 3: waveform mode width.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- Enable_i  in  1  run request; level sensitive.
- Cfg_valid_i  in  1  configuration offer.
- Cfg_ready_o  out  1  configuration can be accepted this cycle.
- Cfg_ftw_i  in  ACC_W  offered tuning word.
- Cfg_mode_i  in  MODE_W  offered mode.
- Address_o  out  ADDR_W  equals acc[ACC_W-1 -: ADDR_W].
- Mode_o  out  MODE_W  active mode.
- Addr_valid_o  out  1  high while in RUN or PEND.
- Wrap_o  out  1  one-cycle pulse marking the first post-wrap address.

## Operation
- Registers: acc (ACC_W), ftw_act, mode_act, ftw_stg, mode_stg, and state in {IDLE, RUN, PEND}.
- Handshake: a transfer occurs when Cfg_valid_i && Cfg_ready_o. Cfg_ready_o = (state != PEND). It is decoded from state and does not depend on Cfg_valid_i.
- IDLE:
  - acc is held at 0.
  - A transfer loads ftw_act and mode_act directly.
  - Enable_i=1 moves to RUN.
- RUN:
  - Each cycle, acc <= (acc + ftw_act) mod 2^ACC_W.
  - A carry out of that sum is a wrap.
  - A transfer loads ftw_stg and mode_stg and moves to PEND.
- PEND:
  - acc keeps advancing as in RUN.
  - On the cycle whose addition wraps, ftw_act <= ftw_stg and mode_act <= mode_stg, and the state returns to RUN.
  - acc keeps the wrapped residue; it is not cleared, so phase stays continuous. The new FTW applies from the next addition.
- Zero FTW: if ftw_act == 0 in PEND, the staged config commits on the next cycle without waiting for a wrap.
- Enable_i=0 in RUN or PEND:
  - Next state is IDLE and acc <= 0.
  - If in PEND, the staged config commits to the active registers and is not discarded.
- Simultaneous events:
  - A transfer on the same cycle as a wrap in RUN is staged and commits at the following wrap.
  - A transfer on the same cycle as Enable_i=0 in RUN commits directly to the active registers, and the state goes to IDLE.
- Width rule: the FTW is unsigned and the addition is modulo 2^ACC_W. Output frequency = f_clk·FTW/2^ACC_W.

## Timing
- Reset (asynchronous, takes effect immediately):
  - acc, ftw_act, mode_act, ftw_stg, mode_stg = 0; state = IDLE.
  - Address_o=0, Mode_o=0, Addr_valid_o=0, Wrap_o=0, Cfg_ready_o=1.
- Reset asserted mid-operation aborts everything; any staged config is lost.
- Transfer latency: a config accepted at edge N in IDLE is visible on Mode_o after edge N.
- Start-up:
  - Enable_i is sampled high at edge N. After N, state=RUN, Addr_valid_o=1, Address_o=0.
  - After edge N+1, Address_o reflects acc=ftw_act.
- Wrap_o is registered. It is high exactly in the cycle after the edge that performed a wrapping addition, which is the same cycle the committed Mode_o/ftw become visible.
- Stop: Enable_i is sampled low at edge M. After M, Addr_valid_o=0 and Address_o=0. Wrap_o is 0 even if a wrap coincided with M.

## Test plan
- Reset and idle outputs:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Response: Address_o=0, Mode_o=0, Addr_valid_o=0, Wrap_o=0, Cfg_ready_o=1.
- Basic run:
  - Stimulus: in IDLE, transfer ftw=0x002000, mode=1; then Enable_i=1.
  - Response: Address_o steps 0,1,2,… per cycle. After 2048 steps Address_o=0 with Wrap_o=1 for one cycle, and Mode_o=1 throughout.
- Glitch-free reconfig:
  - Stimulus: during the basic run at Address_o=100, transfer ftw=0x004000, mode=3.
  - Response:
    - Cfg_ready_o=0 from the next cycle.
    - Mode_o stays 1 and the address keeps stepping by 1 through 2047.
    - The wrap cycle shows Address_o=0, Mode_o=3, Wrap_o=1.
    - Addresses then step by 2, and Cfg_ready_o returns to 1.
- Zero-FTW commit:
  - Stimulus: run with ftw=0 and mode=2 (Address_o stays 0, no Wrap_o); transfer ftw=0x002000, mode=5.
  - Response: Mode_o=5 two edges after the transfer, then Address_o increments by 1 per cycle.
- Disable during PEND:
  - Stimulus: with mode=1 active, transfer mode=4, then drop Enable_i before the wrap.
  - Response: next cycle Addr_valid_o=0, Address_o=0, Mode_o=4, Cfg_ready_o=1. Re-enabling restarts from Address_o=0.
- Asynchronous reset mid-PEND:
  - Stimulus: pulse rst_n low between clock edges.
  - Response: outputs reach their reset values immediately. After release the state is IDLE with mode 0, and the staged config never appears.

Source files
------------

// File: rtl/dds_phase_sequencer.sv
// DDS phase accumulator with wrap-synchronous FTW/mode commit.
// Reconfiguration while running is staged and lands on a phase wrap.
module dds_phase_sequencer #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 11,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Enable_i,
  input  logic              Cfg_valid_i,
  output logic              Cfg_ready_o,
  input  logic [ACC_W-1:0]  Cfg_ftw_i,
  input  logic [MODE_W-1:0] Cfg_mode_i,
  output logic [ADDR_W-1:0] Address_o,
  output logic [MODE_W-1:0] Mode_o,
  output logic              Addr_valid_o,
  output logic              Wrap_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ACC_W-1:0]    acc, acc_d;
  logic [ACC_W-1:0]    ftw_act, ftw_stg;
  logic [MODE_W-1:0]   mode_act, mode_stg;
  logic                wrap_q, wrap_d;

  logic [ACC_W-1:0]    sum;
  logic                carry;
  logic                xfer;
  logic                ld_act;
  logic                ld_stg;
  logic                commit;

  assign {carry, sum} = {1'b0, acc} + {1'b0, ftw_act};
  assign Cfg_ready_o  = (state != PEND);
  assign xfer         = Cfg_valid_i && Cfg_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    wrap_d  = 1'b0;
    ld_act  = 1'b0;
    ld_stg  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        acc_d  = '0;
        ld_act = xfer;
        if (Enable_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!Enable_i) begin
          state_d = IDLE;
          acc_d   = '0;
          ld_act  = xfer;
        end else begin
          acc_d  = sum;
          wrap_d = carry;
          if (xfer) begin
            ld_stg  = 1'b1;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!Enable_i) begin
          state_d = IDLE;
          acc_d   = '0;
          commit  = 1'b1;
        end else begin
          acc_d  = sum;
          wrap_d = carry;
          // a zero FTW never wraps, so commit at once
          if (carry || (ftw_act == '0)) begin
            commit  = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ftw_act  <= '0;
      mode_act <= '0;
      ftw_stg  <= '0;
      mode_stg <= '0;
      wrap_q   <= 1'b0;
    end else begin
      acc    <= acc_d;
      wrap_q <= wrap_d;
      if (ld_act) begin
        ftw_act  <= Cfg_ftw_i;
        mode_act <= Cfg_mode_i;
      end else if (commit) begin
        ftw_act  <= ftw_stg;
        mode_act <= mode_stg;
      end
      if (ld_stg) begin
        ftw_stg  <= Cfg_ftw_i;
        mode_stg <= Cfg_mode_i;
      end
    end
  end

  assign Address_o    = acc[ACC_W-1 -: ADDR_W];
  assign Mode_o       = mode_act;
  assign Addr_valid_o = (state != IDLE);
  assign Wrap_o       = wrap_q;

endmodule
